mux4way_rr_arbiter: RTL and testbench

- Merges four independent valid/ready input channels (a, b, c, d) into one output stream. It is the collecting end of the 4-way demultiplexer path.
- Arbitration is round-robin and packet-aware: a granted channel keeps the output until it presents its last beat.
- A one-entry registered output stage carries the winning channel's index on out_sel. A downstream dmux4way-style splitter can route by that index.

---
 rtl/mux4way_pkg.sv | 16 +
 rtl/rr_pick4.sv | 31 +++
 rtl/mux4way_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux4way_rr_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux4way_pkg.sv
// Shared definitions for the 4-way round-robin merge arbiter.
package mux4way_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  // The pointer starts at the last channel so that channel a is searched first.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  // IDLE: free to pick a new packet. LOCKED: the output belongs to one channel until its last beat.
  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// The search starts at ptr+1 and wraps around, so ptr itself has the lowest priority.
module rr_pick4
  import mux4way_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] grant
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Scan ptr+1, ptr+2, ptr+3, ptr and keep the first request found.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    any   = |req;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4way_rr_arbiter.sv
// Four valid/ready input channels merged into one registered output stream.
// Arbitration is round-robin between packets. A granted channel keeps the output until its last beat.
module mux4way_rr_arbiter
  import mux4way_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*WIDTH-1:0]    in_data,
  input  logic [3:0]            in_valid,
  input  logic [3:0]            in_last,
  output logic [3:0]            in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [1:0]            out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] lock;
  logic [1:0] pick_g;
  logic       pick_any;
  logic [1:0] src;
  logic       ld;
  logic       take;

  rr_pick4 u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .any   (pick_any),
    .grant (pick_g)
  );

  // The output register can take a beat when it is empty or being drained this cycle.
  assign ld   = !out_valid | out_ready;
  assign src  = (state == LOCKED) ? lock : pick_g;
  assign take = |(in_ready & in_valid);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: lock on a multi-beat packet start, release on the locked channel's last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (take && !in_last[pick_g]) state_nxt = LOCKED;
      LOCKED: if (take && in_last[lock])    state_nxt = IDLE;
    endcase
  end

  // Ready decode. In reset it is forced low so no beat can be offered.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      case (state)
        IDLE:   if (ld && pick_any) in_ready[pick_g] = 1'b1;
        LOCKED: in_ready[lock] = ld;
      endcase
    end
  end

  // Pointer and lock follow the channel that started a packet. While locked, ptr already equals lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= PTR_RST;
      lock <= '0;
    end else if (state == IDLE && take) begin
      ptr  <= pick_g;
      lock <= pick_g;
    end
  end

  // One-entry output stage. It loads on an input transfer, empties when drained, and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data fields are reset too, so the outputs read a known zero, not X, before the first beat.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[src*WIDTH +: WIDTH];
      out_last  <= in_last[src];
      out_sel   <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4way_rr_arbiter.sv
// Directed bench for mux4way_rr_arbiter: per-cycle vector table plus a hand-written mid-packet reset.
module tb_mux4way_rr_arbiter;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_last;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  int n_vec  = 0;
  int n_fail = 0;

  mux4way_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // One record per clock cycle. Inputs are driven for the cycle, and expected values are sampled mid-cycle.
  typedef struct {
    bit          do_rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [7:0]  exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [3:0] v, input logic [3:0] l, input logic o,
                     input logic [31:0] d, input logic [3:0] ir, input logic ov,
                     input logic [1:0] s, input logic [7:0] od, input logic ol);
    vec_t x;
    x.do_rst = r; x.valid = v; x.last = l; x.ordy = o; x.data = d;
    x.exp_ir = ir; x.exp_ov = ov; x.exp_sel = s; x.exp_data = od; x.exp_last = ol;
    vq.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst out_data", 32'(out_data), 0);
    check("rst out_sel", 32'(out_sel), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic apply(input int i, input vec_t x);
    if (x.do_rst) do_reset();
    in_valid = x.valid; in_last = x.last; out_ready = x.ordy; in_data = x.data;
    #4;
    check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(x.exp_ir));
    check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(x.exp_ov));
    if (x.exp_ov) begin
      check($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(x.exp_sel));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(x.exp_data));
      check($sformatf("v%0d out_last", i), 32'(out_last), 32'(x.exp_last));
    end
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] DA = 32'h0D0C0B0A;

  initial begin
    rst = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;

    // All four channels valid with single-beat packets: strict rotation a,b,c,d,a,... then drain.
    add(1, 4'hF, 4'hF, 1, DA, 4'b0001, 0, 0, 8'h00, 0);
    add(0, 4'hF, 4'hF, 1, DA, 4'b0010, 1, 0, 8'h0A, 1);
    add(0, 4'hF, 4'hF, 1, DA, 4'b0100, 1, 1, 8'h0B, 1);
    add(0, 4'hF, 4'hF, 1, DA, 4'b1000, 1, 2, 8'h0C, 1);
    add(0, 4'hF, 4'hF, 1, DA, 4'b0001, 1, 3, 8'h0D, 1);
    add(0, 4'hF, 4'hF, 1, DA, 4'b0010, 1, 0, 8'h0A, 1);
    add(0, 4'h0, 4'h0, 1, DA, 4'b0000, 1, 1, 8'h0B, 1);
    add(0, 4'h0, 4'h0, 1, DA, 4'b0000, 0, 0, 8'h00, 0);

    // a and d only: alternate 0,3,0,3. b and c are never readied.
    add(1, 4'b1001, 4'hF, 1, DA, 4'b0001, 0, 0, 8'h00, 0);
    add(0, 4'b1001, 4'hF, 1, DA, 4'b1000, 1, 0, 8'h0A, 1);
    add(0, 4'b1001, 4'hF, 1, DA, 4'b0001, 1, 3, 8'h0D, 1);
    add(0, 4'b1001, 4'hF, 1, DA, 4'b1000, 1, 0, 8'h0A, 1);
    add(0, 4'b1001, 4'hF, 1, DA, 4'b0001, 1, 3, 8'h0D, 1);

    // b sends a 3-beat packet while c waits. c is granted only after b's last beat.
    add(1, 4'b0110, 4'b0100, 1, 32'h00211100, 4'b0010, 0, 0, 8'h00, 0);
    add(0, 4'b0110, 4'b0100, 1, 32'h00211200, 4'b0010, 1, 1, 8'h11, 0);
    add(0, 4'b0110, 4'b0110, 1, 32'h00211300, 4'b0010, 1, 1, 8'h12, 0);
    add(0, 4'b0100, 4'b0110, 1, 32'h00211300, 4'b0100, 1, 1, 8'h13, 1);
    add(0, 4'b0000, 4'b0000, 1, 32'h00000000, 4'b0000, 1, 2, 8'h21, 1);

    // Locked on d. d goes idle for 4 cycles while a is valid. Only d's ready can be high (it follows ld).
    add(1, 4'b1000, 4'b0000, 1, 32'h31000000, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b0001, 4'b0001, 1, 32'h3100000A, 4'b1000, 1, 3, 8'h31, 0);
    add(0, 4'b0001, 4'b0001, 1, 32'h3100000A, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b0001, 4'b0001, 1, 32'h3100000A, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b0001, 4'b0001, 1, 32'h3100000A, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b1001, 4'b1001, 1, 32'h3200000A, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b0001, 4'b0001, 1, 32'h3200000A, 4'b0001, 1, 3, 8'h32, 1);
    add(0, 4'b0000, 4'b0000, 1, 32'h00000000, 4'b0000, 1, 0, 8'h0A, 1);

    // Back-pressure: 5A from c is held for 5 stalled cycles, then 5B follows with no bubble.
    add(1, 4'b0100, 4'b0100, 1, 32'h005A0000, 4'b0100, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0100, 4'b0100, 0, 32'h005B0000, 4'b0000, 1, 2, 8'h5A, 1);
    add(0, 4'b0100, 4'b0100, 1, 32'h005B0000, 4'b0100, 1, 2, 8'h5A, 1);
    add(0, 4'b0000, 4'b0000, 1, 32'h00000000, 4'b0000, 1, 2, 8'h5B, 1);

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    // Reset in the middle of a packet locked on b.
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000; in_data = 32'h00004100; out_ready = 1'b1;
    #1;
    check("mid in_ready b", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    check("mid out_valid", 32'(out_valid), 1);
    check("mid out_data", 32'(out_data), 32'h41);
    rst = 1'b1;
    #1;
    check("mid rst out_valid", 32'(out_valid), 0);
    check("mid rst in_ready", 32'(in_ready), 0);
    check("mid rst out_data", 32'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 4'hF; in_last = 4'hF; in_data = DA;
    #1;
    check("post rst all valid", 32'(in_ready), 32'b0001);
    in_valid = 4'b0100;
    #1;
    check("post rst c only", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    in_valid = '0;
    #1;
    check("post rst out_valid", 32'(out_valid), 1);
    check("post rst out_sel", 32'(out_sel), 2);
    check("post rst out_data", 32'(out_data), 32'h0C);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
